bram_req_ctrl: RTL

//  Upstream front-end for one port of bram_block. Converts a valid/ready request

---
 rtl/bram_req_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/bram_req_ctrl.sv
// Request front-end for one bram_block port: turns a valid/ready request stream
// into raw BRAM port signals and queues registered read data in a response FIFO.
module bram_req_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int RESP_DEPTH = 3,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(RESP_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic [AW-1:0]    bram_addr,
  output logic             bram_we,
  output logic [WIDTH-1:0] bram_din,
  input  logic [WIDTH-1:0] bram_dout,
  output logic [CW-1:0]    resp_count
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [WIDTH-1:0] mem [RESP_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             inflight;
  logic             fire;
  logic             push;
  logic             pop;
  logic [CW:0]      credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A read in flight already owns a FIFO slot, so it is counted against the credit.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign req_ready   = !reset && (credit_used < (CW+1)'(RESP_DEPTH));
  assign fire        = req_valid && req_ready;

  assign bram_addr   = req_addr;
  assign bram_din    = req_wdata;
  assign bram_we     = fire && req_we;

  assign push        = inflight;
  assign resp_valid  = (count != '0);
  assign pop         = resp_valid && resp_ready;
  assign resp_rdata  = resp_valid ? mem[rd_ptr] : '0;
  assign resp_count  = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= fire && !req_we;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bram_dout;
  end

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= CW'(RESP_DEPTH));
  a_push_not_full: assert property (@(posedge clk) disable iff (reset)
    push |-> (count < CW'(RESP_DEPTH) || pop));
`endif

endmodule
